alu_rs: RTL and testbench

- ALU reservation station; the initiator side of the ALU operand interface.
- Accepts decoded ALU ops from dispatch, holds them until both operands are known, and drives op1/op2/alu_op into the combinational ALU.
- Captures the ALU result and broadcasts it, tagged, toward the CDB arbiter.
- Snoops the CDB to wake waiting operands.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_rs_pick.sv | 36 +++
 rtl/alu_rs.sv | 180 ++++++++++++++++++
 tb/tb_alu_rs.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and datapath widths.
// Opcodes 4'b1100..4'b1111 are accepted by the station but produce a zero result.
package alu_pkg;

    localparam int ALU_OP_W = 4;
    localparam int XLEN     = 32;

    localparam logic [ALU_OP_W-1:0] AUIPC = 4'd0;
    localparam logic [ALU_OP_W-1:0] ADD   = 4'd1;
    localparam logic [ALU_OP_W-1:0] SUB   = 4'd2;
    localparam logic [ALU_OP_W-1:0] AND   = 4'd3;
    localparam logic [ALU_OP_W-1:0] OR    = 4'd4;
    localparam logic [ALU_OP_W-1:0] XOR   = 4'd5;
    localparam logic [ALU_OP_W-1:0] SLL   = 4'd6;
    localparam logic [ALU_OP_W-1:0] SRL   = 4'd7;
    localparam logic [ALU_OP_W-1:0] SRA   = 4'd8;
    localparam logic [ALU_OP_W-1:0] SLT   = 4'd9;
    localparam logic [ALU_OP_W-1:0] SLTU  = 4'd10;
    localparam logic [ALU_OP_W-1:0] LUI   = 4'd11;

    function automatic logic op_result_zero(input logic [ALU_OP_W-1:0] op);
        return op[3] & op[2];
    endfunction

endpackage

// File: rtl/alu_rs_pick.sv
// Priority / oldest-first selector: one-hot grant plus binary index of the winner.
// With OLDEST=0 the age input is ignored and the lowest-index request wins.
module alu_rs_pick #(
    parameter int N     = 4,
    parameter int AGE_W = 1,
    parameter bit OLDEST = 1'b0
) (
    input  logic [N-1:0]         req,
    input  logic [N*AGE_W-1:0]   age,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IDX_W = $clog2(N);

    logic             found;
    logic [AGE_W-1:0] best;

    // Strict greater-than keeps ties with the lower index.
    always_comb begin
        found = 1'b0;
        best  = '0;
        idx   = '0;
        grant = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i] && (!found || (OLDEST && (age[i*AGE_W +: AGE_W] > best)))) begin
                found    = 1'b1;
                best     = age[i*AGE_W +: AGE_W];
                idx      = IDX_W'(i);
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops until operands arrive, issues to the ALU,
// registers the tagged result for the CDB. Optional macro ALU_RS_AGE_ORDER_EN: oldest-ready issue.
module alu_rs
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                flush_in,
    input  logic                disp_valid,
    input  logic [ALU_OP_W-1:0] disp_op,
    input  logic [XLEN-1:0]     disp_vj,
    input  logic                disp_qj_busy,
    input  logic [TAG_W-1:0]    disp_qj,
    input  logic [XLEN-1:0]     disp_vk,
    input  logic                disp_qk_busy,
    input  logic [TAG_W-1:0]    disp_qk,
    input  logic [TAG_W-1:0]    disp_dest,
    output logic                rs_full,
    input  logic                cdb_valid,
    input  logic [TAG_W-1:0]    cdb_tag,
    input  logic [XLEN-1:0]     cdb_value,
    output logic [XLEN-1:0]     alu_op1,
    output logic [XLEN-1:0]     alu_op2,
    output logic [ALU_OP_W-1:0] alu_op,
    input  logic [XLEN-1:0]     alu_result,
    output logic                out_valid,
    output logic [TAG_W-1:0]    out_tag,
    output logic [XLEN-1:0]     out_value
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic                busy;
        logic [ALU_OP_W-1:0] op;
        logic [XLEN-1:0]     vj;
        logic                qj_busy;
        logic [TAG_W-1:0]    qj;
        logic [XLEN-1:0]     vk;
        logic                qk_busy;
        logic [TAG_W-1:0]    qk;
        logic [TAG_W-1:0]    dest;
    } entry_t;

    entry_t             ent [DEPTH];
    entry_t             disp_entry;
    logic [DEPTH-1:0]   busy_vec;
    logic [DEPTH-1:0]   ready_vec;
    logic [DEPTH-1:0]   free_oh;
    logic [IDX_W-1:0]   free_idx;
    logic [DEPTH-1:0]   issue_oh;
    logic [IDX_W-1:0]   issue_idx;
    logic               issue_any;
    logic               disp_fire;
    logic               hit_j;
    logic               hit_k;

    always_comb begin
        busy_vec  = '0;
        ready_vec = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            busy_vec[i]  = ent[i].busy;
            ready_vec[i] = ent[i].busy & ~ent[i].qj_busy & ~ent[i].qk_busy;
        end
    end

    alu_rs_pick #(.N(DEPTH), .AGE_W(1), .OLDEST(1'b0)) u_free_pick (
        .req   (~busy_vec),
        .age   ('0),
        .grant (free_oh),
        .idx   (free_idx)
    );

`ifdef ALU_RS_AGE_ORDER_EN
    localparam int AGE_W = IDX_W + 1;

    logic [AGE_W-1:0]       age [DEPTH];
    logic [DEPTH*AGE_W-1:0] age_flat;

    always_comb begin
        age_flat = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            age_flat[i*AGE_W +: AGE_W] = age[i];
        end
    end

    // Ages of idle entries also advance; they are rewritten to 0 on dispatch.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int unsigned i = 0; i < DEPTH; i++) age[i] <= '0;
        end else if (!flush_in && rdy_in) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (disp_fire && free_oh[i]) age[i] <= '0;
                else if (age[i] != '1)       age[i] <= age[i] + AGE_W'(1);
            end
        end
    end

    alu_rs_pick #(.N(DEPTH), .AGE_W(AGE_W), .OLDEST(1'b1)) u_issue_pick (
        .req   (ready_vec),
        .age   (age_flat),
        .grant (issue_oh),
        .idx   (issue_idx)
    );
`else
    alu_rs_pick #(.N(DEPTH), .AGE_W(1), .OLDEST(1'b0)) u_issue_pick (
        .req   (ready_vec),
        .age   ('0),
        .grant (issue_oh),
        .idx   (issue_idx)
    );
`endif

    assign issue_any = |issue_oh;
    assign rs_full   = ~|free_oh;
    assign disp_fire = disp_valid & ~rs_full;

    assign hit_j = cdb_valid && disp_qj_busy && (disp_qj == cdb_tag);
    assign hit_k = cdb_valid && disp_qk_busy && (disp_qk == cdb_tag);

    always_comb begin
        disp_entry         = '0;
        disp_entry.busy    = 1'b1;
        disp_entry.op      = disp_op;
        disp_entry.vj      = hit_j ? cdb_value : disp_vj;
        disp_entry.qj_busy = disp_qj_busy & ~hit_j;
        disp_entry.qj      = disp_qj;
        disp_entry.vk      = hit_k ? cdb_value : disp_vk;
        disp_entry.qk_busy = disp_qk_busy & ~hit_k;
        disp_entry.qk      = disp_qk;
        disp_entry.dest    = disp_dest;
    end

    always_comb begin
        alu_op1 = '0;
        alu_op2 = '0;
        alu_op  = '0;
        if (issue_any) begin
            alu_op1 = ent[issue_idx].vj;
            alu_op2 = ent[issue_idx].vk;
            alu_op  = ent[issue_idx].op;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int unsigned i = 0; i < DEPTH; i++) ent[i] <= '0;
            out_valid <= 1'b0;
            out_tag   <= '0;
            out_value <= '0;
        end else if (flush_in) begin
            for (int unsigned i = 0; i < DEPTH; i++) ent[i].busy <= 1'b0;
            out_valid <= 1'b0;
        end else if (rdy_in) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (issue_oh[i]) ent[i].busy <= 1'b0;
                if (ent[i].busy && ent[i].qj_busy && cdb_valid && (ent[i].qj == cdb_tag)) begin
                    ent[i].vj      <= cdb_value;
                    ent[i].qj_busy <= 1'b0;
                end
                if (ent[i].busy && ent[i].qk_busy && cdb_valid && (ent[i].qk == cdb_tag)) begin
                    ent[i].vk      <= cdb_value;
                    ent[i].qk_busy <= 1'b0;
                end
            end
            // The free entry is never busy, so this write cannot collide with the loop above.
            if (disp_fire) ent[free_idx] <= disp_entry;
            out_valid <= issue_any;
            if (issue_any) begin
                out_tag   <= ent[issue_idx].dest;
                out_value <= op_result_zero(ent[issue_idx].op) ? '0 : alu_result;
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Scoreboard bench for alu_rs: expected results queued at stimulus time, checked on out_valid.
module tb_alu_rs;
    import alu_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             clk_in = 1'b0;
    logic             rst_in, rdy_in, flush_in;
    logic             disp_valid;
    logic [3:0]       disp_op;
    logic [31:0]      disp_vj, disp_vk;
    logic             disp_qj_busy, disp_qk_busy;
    logic [TAG_W-1:0] disp_qj, disp_qk, disp_dest;
    logic             rs_full;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_value;
    logic [31:0]      alu_op1, alu_op2, alu_result;
    logic [3:0]       alu_op;
    logic             out_valid;
    logic [TAG_W-1:0] out_tag;
    logic [31:0]      out_value;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      value;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic live = 1'b0;

    always #5 clk_in = ~clk_in;

    alu_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .flush_in     (flush_in),
        .disp_valid   (disp_valid),
        .disp_op      (disp_op),
        .disp_vj      (disp_vj),
        .disp_qj_busy (disp_qj_busy),
        .disp_qj      (disp_qj),
        .disp_vk      (disp_vk),
        .disp_qk_busy (disp_qk_busy),
        .disp_qk      (disp_qk),
        .disp_dest    (disp_dest),
        .rs_full      (rs_full),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_value    (cdb_value),
        .alu_op1      (alu_op1),
        .alu_op2      (alu_op2),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .out_valid    (out_valid),
        .out_tag      (out_tag),
        .out_value    (out_value)
    );

    // Reference ALU; unused opcodes return a marker so the station's zero-forcing is visible.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            AUIPC, ADD: return a + b;
            SUB:        return a - b;
            AND:        return a & b;
            OR:         return a | b;
            XOR:        return a ^ b;
            SLL:        return a << b[4:0];
            SRL:        return a >> b[4:0];
            SRA:        return $unsigned($signed(a) >>> b[4:0]);
            SLT:        return {31'b0, $signed(a) < $signed(b)};
            SLTU:       return {31'b0, a < b};
            LUI:        return b;
            default:    return 32'hDEAD_BEEF;
        endcase
    endfunction

    always_comb alu_result = ref_alu(alu_op, alu_op1, alu_op2);

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic push(input logic [TAG_W-1:0] tag, input logic [31:0] value);
        sb.push_back('{tag: tag, value: value});
    endtask

    // A fresh result exists only after an edge that was not stalled, flushed or reset.
    always @(posedge clk_in) live <= rdy_in & ~rst_in & ~flush_in;

    always @(negedge clk_in) begin
        if (live && out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out", {28'b0, out_tag}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_tag", {28'b0, out_tag}, {28'b0, e.tag});
                check("out_value", out_value, e.value);
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic disp(input logic [3:0] op, input logic [31:0] vj, input logic qjb, input logic [3:0] qj,
                        input logic [31:0] vk, input logic qkb, input logic [3:0] qk, input logic [3:0] dest);
        disp_valid = 1'b1; disp_op = op;
        disp_vj = vj; disp_qj_busy = qjb; disp_qj = qj;
        disp_vk = vk; disp_qk_busy = qkb; disp_qk = qk;
        disp_dest = dest;
        step();
        disp_valid = 1'b0;
    endtask

    task automatic cdb(input logic [3:0] tag, input logic [31:0] value);
        cdb_valid = 1'b1; cdb_tag = tag; cdb_value = value;
        step();
        cdb_valid = 1'b0;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0;
        disp_valid = 1'b0; disp_op = '0; disp_vj = '0; disp_vk = '0;
        disp_qj_busy = 1'b0; disp_qk_busy = 1'b0; disp_qj = '0; disp_qk = '0; disp_dest = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
        step(); step();
        rst_in = 1'b0;

        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_rs_full", {31'b0, rs_full}, 0);
        check("rst_out_tag", {28'b0, out_tag}, 0);
        check("rst_out_value", out_value, 0);
        check("rst_alu_op", {28'b0, alu_op}, 0);
        check("rst_alu_op1", alu_op1, 0);
        check("rst_alu_op2", alu_op2, 0);

        // Basic issue: ADD 5+7
        push(4'd3, 32'd12);
        disp(ADD, 32'd5, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0, 4'd3);
        check("add_alu_op", {28'b0, alu_op}, {28'b0, ADD});
        check("add_alu_op1", alu_op1, 32'd5);
        check("add_alu_op2", alu_op2, 32'd7);
        step();
        check("add_out_valid", {31'b0, out_valid}, 1);

        // Wakeup of a pending operand
        push(4'd4, 32'd9);
        disp(SUB, 32'h0, 1'b1, 4'd9, 32'd1, 1'b0, 4'd0, 4'd4);
        for (int i = 0; i < 3; i++) begin
            check("wait_no_out", {31'b0, out_valid}, 0);
            step();
        end
        cdb(4'd9, 32'd10);
        check("wake_alu_op", {28'b0, alu_op}, {28'b0, SUB});
        check("wake_alu_op1", alu_op1, 32'd10);
        step();
        check("wake_out_valid", {31'b0, out_valid}, 1);

        // Same-cycle CDB bypass at dispatch
        push(4'd5, 32'hFFFF_0000);
        cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_value = 32'h8000_0000;
        disp(SRA, 32'hFFFF_0000, 1'b0, 4'd0, 32'h0, 1'b1, 4'd2, 4'd5);
        cdb_valid = 1'b0;
        check("byp_alu_op", {28'b0, alu_op}, {28'b0, SRA});
        check("byp_alu_op2", alu_op2, 32'h8000_0000);
        step();

        // Reserved opcode: issued, result forced to zero
        push(4'd6, 32'd0);
        disp(4'd13, 32'd3, 1'b0, 4'd0, 32'd4, 1'b0, 4'd0, 4'd6);
        step();

        // Fill the station, ignore an extra dispatch, drain one per cycle
        for (int i = 0; i < DEPTH; i++) begin
            push(4'(8 + i), 32'd20 + 32'(100 + i));
            disp(ADD, 32'h0, 1'b1, 4'd1, 32'(100 + i), 1'b0, 4'd0, 4'(8 + i));
        end
        check("full_set", {31'b0, rs_full}, 1);
        disp(SUB, 32'h0, 1'b1, 4'd1, 32'd77, 1'b0, 4'd0, 4'd15);
        check("full_hold", {31'b0, rs_full}, 1);
        cdb(4'd1, 32'd20);
        check("full_before_issue", {31'b0, rs_full}, 1);
        step();
        check("full_after_issue", {31'b0, rs_full}, 0);
        for (int i = 0; i < DEPTH; i++) step();

        // Flush while an entry is issuing, with a simultaneous dispatch
        for (int i = 0; i < 3; i++) disp(ADD, 32'h0, 1'b1, 4'd11, 32'd1, 1'b0, 4'd0, 4'(1 + i));
        disp(ADD, 32'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 4'd12);
        check("pre_flush_full", {31'b0, rs_full}, 1);
        check("pre_flush_sel", {28'b0, alu_op}, {28'b0, ADD});
        flush_in = 1'b1;
        disp(ADD, 32'd2, 1'b0, 4'd0, 32'd2, 1'b0, 4'd0, 4'd13);
        flush_in = 1'b0;
        check("flush_out_valid", {31'b0, out_valid}, 0);
        check("flush_rs_full", {31'b0, rs_full}, 0);
        check("flush_alu_op", {28'b0, alu_op}, 0);
        cdb(4'd11, 32'd5);
        check("flush_no_wake", {28'b0, alu_op}, 0);
        step();
        check("flush_no_out", {31'b0, out_valid}, 0);

        // rdy_in low for two cycles mid-issue
        push(4'd1, 32'd3);
        disp(ADD, 32'd1, 1'b0, 4'd0, 32'd2, 1'b0, 4'd0, 4'd1);
        push(4'd2, 32'h0000_000F);
        disp(XOR, 32'hF0, 1'b0, 4'd0, 32'hFF, 1'b0, 4'd0, 4'd2);
        rdy_in = 1'b0;
        disp_valid = 1'b1; disp_op = ADD; disp_vj = 32'd9; disp_vk = 32'd9;
        disp_qj_busy = 1'b0; disp_qk_busy = 1'b0; disp_dest = 4'd9;
        cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_value = 32'h1234;
        for (int i = 0; i < 3; i++) begin
            check("stall_out_valid", {31'b0, out_valid}, 1);
            check("stall_out_tag", {28'b0, out_tag}, 1);
            check("stall_out_value", out_value, 32'd3);
            check("stall_alu_op", {28'b0, alu_op}, {28'b0, XOR});
            check("stall_alu_op1", alu_op1, 32'hF0);
            if (i < 2) step();
        end
        rdy_in = 1'b1; disp_valid = 1'b0; cdb_valid = 1'b0;
        step();
        check("resume_out_tag", {28'b0, out_tag}, 2);
        step();

        // Ordering: entry 2 (older) and entry 0 (younger) wake together
        push(4'd1, 32'd11);
        disp(ADD, 32'h0, 1'b1, 4'd5, 32'd1, 1'b0, 4'd0, 4'd1);
        disp(ADD, 32'h0, 1'b1, 4'd6, 32'd1, 1'b0, 4'd0, 4'd2);
        disp(SUB, 32'h0, 1'b1, 4'd7, 32'd1, 1'b0, 4'd0, 4'd3);
        cdb(4'd5, 32'd10);
        step(); step();
        disp(OR, 32'h0, 1'b1, 4'd7, 32'h100, 1'b0, 4'd0, 4'd4);
`ifdef ALU_RS_AGE_ORDER_EN
        push(4'd3, 32'h4F);
        push(4'd4, 32'h150);
        cdb(4'd7, 32'h50);
        check("order_first", {28'b0, alu_op}, {28'b0, SUB});
        step();
        check("order_second", {28'b0, alu_op}, {28'b0, OR});
`else
        push(4'd4, 32'h150);
        push(4'd3, 32'h4F);
        cdb(4'd7, 32'h50);
        check("order_first", {28'b0, alu_op}, {28'b0, OR});
        step();
        check("order_second", {28'b0, alu_op}, {28'b0, SUB});
`endif
        step();
        push(4'd2, 32'd3);
        cdb(4'd6, 32'd2);

        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        step(); step();
        check("sb_drained", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
